// File: rtl/three_bit.sv
//------------------------------------------------------------------------------
// Module   : three_bit
// Purpose  : 3-bit unsigned ripple-carry adder with registered sum and carry-out.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module three_bit (
    input  logic clk,
    input  logic rst,
    output logic sum0,
    output logic sum1,
    output logic sum2,
    output logic cout,
    input  logic x0,
    input  logic x1,
    input  logic x2,
    input  logic y0,
    input  logic y1,
    input  logic y2
);

    localparam int c_WIDTH = 3;

    logic [c_WIDTH-1:0] w_x;
    logic [c_WIDTH-1:0] w_y;
    logic [c_WIDTH-1:0] w_sum;
    logic [c_WIDTH:0]   w_carry;

    logic [c_WIDTH-1:0] r_sum;
    logic               r_cout;

    assign w_x = {x2, x1, x0};
    assign w_y = {y2, y1, y0};

    // Ripple chain of full-adder slices; bit-0 carry-in is tied low.
    always_comb begin
        w_carry    = '0;
        w_sum      = '0;
        w_carry[0] = 1'b0;
        for (int i = 0; i < c_WIDTH; i++) begin
            w_sum[i]     = w_x[i] ^ w_y[i] ^ w_carry[i];
            w_carry[i+1] = (w_x[i] & w_y[i]) | (w_carry[i] & (w_x[i] ^ w_y[i]));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= '0;
            r_cout <= 1'b0;
        end else begin
            r_sum  <= w_sum;
            r_cout <= w_carry[c_WIDTH];
        end
    end

    assign sum0 = r_sum[0];
    assign sum1 = r_sum[1];
    assign sum2 = r_sum[2];
    assign cout = r_cout;

endmodule

`default_nettype wire

// File: tb/tb_three_bit.sv
//------------------------------------------------------------------------------
// Module   : tb_three_bit
// Purpose  : Directed self-checking bench for the three_bit registered adder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_three_bit;

    logic clk;
    logic rst;
    logic x0, x1, x2;
    logic y0, y1, y2;
    logic sum0, sum1, sum2, cout;

    int checks;
    int errors;

    three_bit dut (
        .clk  (clk),
        .rst  (rst),
        .sum0 (sum0),
        .sum1 (sum1),
        .sum2 (sum2),
        .cout (cout),
        .x0   (x0),
        .x1   (x1),
        .x2   (x2),
        .y0   (y0),
        .y1   (y1),
        .y2   (y2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands, let one rising edge sample them, then settle 1 time unit.
    task automatic drive(input logic [2:0] a, input logic [2:0] b, input logic r);
        {x2, x1, x0} = a;
        {y2, y1, y0} = b;
        rst          = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        drive(3'd7, 3'd7, 1'b1);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_edge1 got %b want 0000", {cout, sum2, sum1, sum0});
        end
        drive(3'd7, 3'd7, 1'b1);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_edge2 got %b want 0000", {cout, sum2, sum1, sum0});
        end
        drive(3'd7, 3'd7, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_release got %b want 1110", {cout, sum2, sum1, sum0});
        end
    endtask

    task automatic test_small_sweep();
        logic [3:0] exp;
        for (int a = 0; a < 3; a++) begin
            for (int b = 0; b < 3; b++) begin
                drive(a[2:0], b[2:0], 1'b0);
                exp = 4'(a + b);
                checks++;
                if ({cout, sum2, sum1, sum0} !== exp) begin
                    errors++;
                    $display("FAIL small_sweep x=%0d y=%0d got %b want %b",
                             a, b, {cout, sum2, sum1, sum0}, exp);
                end
            end
        end
    endtask

    task automatic test_carry_ripple();
        drive(3'b111, 3'b001, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b1000) begin
            errors++;
            $display("FAIL ripple_7p1 got %b want 1000", {cout, sum2, sum1, sum0});
        end
        drive(3'b011, 3'b001, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b0100) begin
            errors++;
            $display("FAIL ripple_3p1 got %b want 0100", {cout, sum2, sum1, sum0});
        end
        drive(3'b010, 3'b011, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b0101) begin
            errors++;
            $display("FAIL ripple_2p3 got %b want 0101", {cout, sum2, sum1, sum0});
        end
    endtask

    task automatic test_extremes();
        drive(3'd0, 3'd0, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b0000) begin
            errors++;
            $display("FAIL extreme_0p0 got %b want 0000", {cout, sum2, sum1, sum0});
        end
        drive(3'd7, 3'd7, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b1110) begin
            errors++;
            $display("FAIL extreme_7p7 got %b want 1110", {cout, sum2, sum1, sum0});
        end
        drive(3'd4, 3'd4, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b1000) begin
            errors++;
            $display("FAIL extreme_4p4 got %b want 1000", {cout, sum2, sum1, sum0});
        end
        drive(3'd7, 3'd0, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b0111) begin
            errors++;
            $display("FAIL extreme_7p0 got %b want 0111", {cout, sum2, sum1, sum0});
        end
    endtask

    // All 64 pairs, one per cycle, against an integer-add reference.
    task automatic test_back_to_back();
        logic [3:0] exp;
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                drive(a[2:0], b[2:0], 1'b0);
                exp = 4'(a + b);
                checks++;
                if ({cout, sum2, sum1, sum0} !== exp) begin
                    errors++;
                    $display("FAIL exhaustive x=%0d y=%0d got %b want %b",
                             a, b, {cout, sum2, sum1, sum0}, exp);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        drive(3'd6, 3'd5, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b1011) begin
            errors++;
            $display("FAIL mid_before got %b want 1011", {cout, sum2, sum1, sum0});
        end
        drive(3'd5, 3'd6, 1'b1);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b0000) begin
            errors++;
            $display("FAIL mid_reset got %b want 0000", {cout, sum2, sum1, sum0});
        end
        drive(3'd3, 3'd2, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b0101) begin
            errors++;
            $display("FAIL mid_after got %b want 0101", {cout, sum2, sum1, sum0});
        end
        drive(3'd1, 3'd7, 1'b0);
        checks++;
        if ({cout, sum2, sum1, sum0} !== 4'b1000) begin
            errors++;
            $display("FAIL mid_next got %b want 1000", {cout, sum2, sum1, sum0});
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        {x2, x1, x0} = 3'd0;
        {y2, y1, y0} = 3'd0;
        @(negedge clk);
        test_reset();
        test_small_sweep();
        test_carry_ripple();
        test_extremes();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
